// File: rtl/pipeline_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline: widths, control-bit
// indices and forwarding-select encodings.
package pipeline_pkg;

  localparam int DATA_W  = 32;
  localparam int REG_W   = 5;
  localparam int ALUOP_W = 4;
  localparam int CTRL_W  = 6;

  localparam int CTRL_REGWRITE = 5;
  localparam int CTRL_MEMTOREG = 4;
  localparam int CTRL_MEMREAD  = 3;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_ALUSRC   = 1;
  localparam int CTRL_REGDST   = 0;

  localparam int ZERO_REG = 0;

  // ForA/ForB operand-select encodings used by the forwarding unit
  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard detection and front-end write enables.
// Store-data dependencies on a load are left to the MEM-stage forward.
module hazard_detect
  import pipeline_pkg::*;
#(
  parameter int REG_W_P = REG_W
) (
  input  logic               ID_Valid,
  input  logic [REG_W_P-1:0] ID_RegRs,
  input  logic [REG_W_P-1:0] ID_RegRt,
  input  logic               ID_UsesRs,
  input  logic               ID_UsesRt,
  input  logic               id_mem_write,
  input  logic               IDEX_Valid,
  input  logic               idex_mem_read,
  input  logic [REG_W_P-1:0] IDEX_RegRt,
  input  logic               Flush,
  input  logic               ExHold,
  output logic               load_use,
  output logic               PCWrite,
  output logic               IFID_Write
);

  logic rs_match;
  logic rt_match;

  always_comb begin
    rs_match = ID_UsesRs & (ID_RegRs == IDEX_RegRt);
    rt_match = ID_UsesRt & ~id_mem_write & (ID_RegRt == IDEX_RegRt);
    load_use = ID_Valid & IDEX_Valid & idex_mem_read
             & (IDEX_RegRt != REG_W_P'(ZERO_REG))
             & (rs_match | rt_match);
    // A flush discards the dependent instruction, so the front end may advance
    PCWrite    = ~ExHold & ~(load_use & ~Flush);
    IFID_Write = PCWrite;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion.
// Optional macro IDEX_STALL_COUNT_EN adds a saturating StallCount output.
module id_ex_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_W  = pipeline_pkg::DATA_W,
  parameter int REG_W   = pipeline_pkg::REG_W,
  parameter int ALUOP_W = pipeline_pkg::ALUOP_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ID_Valid,
  input  logic [REG_W-1:0]   ID_RegRs,
  input  logic [REG_W-1:0]   ID_RegRt,
  input  logic [REG_W-1:0]   ID_RegRd,
  input  logic               ID_UsesRs,
  input  logic               ID_UsesRt,
  input  logic [DATA_W-1:0]  ID_ReadData1,
  input  logic [DATA_W-1:0]  ID_ReadData2,
  input  logic [DATA_W-1:0]  ID_Imm,
  input  logic [CTRL_W-1:0]  ID_Ctrl,
  input  logic [ALUOP_W-1:0] ID_ALUOp,
  input  logic               Flush,
  input  logic               ExHold,
  output logic               PCWrite,
  output logic               IFID_Write,
  output logic               IDEX_Valid,
  output logic [REG_W-1:0]   IDEX_RegRs,
  output logic [REG_W-1:0]   IDEX_RegRt,
  output logic [REG_W-1:0]   IDEX_WriteReg,
  output logic [DATA_W-1:0]  IDEX_ReadData1,
  output logic [DATA_W-1:0]  IDEX_ReadData2,
  output logic [DATA_W-1:0]  IDEX_Imm,
  output logic [CTRL_W-1:0]  IDEX_Ctrl,
  output logic [ALUOP_W-1:0] IDEX_ALUOp
`ifdef IDEX_STALL_COUNT_EN
  ,
  output logic [31:0]        StallCount
`endif
);

  logic               load_use;

  logic               valid_q,     valid_d;
  logic [REG_W-1:0]   reg_rs_q,    reg_rs_d;
  logic [REG_W-1:0]   reg_rt_q,    reg_rt_d;
  logic [REG_W-1:0]   write_reg_q, write_reg_d;
  logic [DATA_W-1:0]  rd1_q,       rd1_d;
  logic [DATA_W-1:0]  rd2_q,       rd2_d;
  logic [DATA_W-1:0]  imm_q,       imm_d;
  logic [CTRL_W-1:0]  ctrl_q,      ctrl_d;
  logic [ALUOP_W-1:0] aluop_q,     aluop_d;

  hazard_detect #(
    .REG_W_P (REG_W)
  ) u_hazard_detect (
    .ID_Valid      (ID_Valid),
    .ID_RegRs      (ID_RegRs),
    .ID_RegRt      (ID_RegRt),
    .ID_UsesRs     (ID_UsesRs),
    .ID_UsesRt     (ID_UsesRt),
    .id_mem_write  (ID_Ctrl[CTRL_MEMWRITE]),
    .IDEX_Valid    (valid_q),
    .idex_mem_read (ctrl_q[CTRL_MEMREAD]),
    .IDEX_RegRt    (reg_rt_q),
    .Flush         (Flush),
    .ExHold        (ExHold),
    .load_use      (load_use),
    .PCWrite       (PCWrite),
    .IFID_Write    (IFID_Write)
  );

  // Hold beats everything; flush, load-use and an empty ID all become a bubble
  always_comb begin
    valid_d     = valid_q;
    reg_rs_d    = reg_rs_q;
    reg_rt_d    = reg_rt_q;
    write_reg_d = write_reg_q;
    rd1_d       = rd1_q;
    rd2_d       = rd2_q;
    imm_d       = imm_q;
    ctrl_d      = ctrl_q;
    aluop_d     = aluop_q;
    if (!ExHold) begin
      if (Flush || load_use || !ID_Valid) begin
        valid_d     = 1'b0;
        reg_rs_d    = '0;
        reg_rt_d    = '0;
        write_reg_d = '0;
        rd1_d       = '0;
        rd2_d       = '0;
        imm_d       = '0;
        ctrl_d      = '0;
        aluop_d     = '0;
      end else begin
        valid_d     = 1'b1;
        reg_rs_d    = ID_RegRs;
        reg_rt_d    = ID_RegRt;
        write_reg_d = ID_Ctrl[CTRL_REGDST] ? ID_RegRd : ID_RegRt;
        rd1_d       = ID_ReadData1;
        rd2_d       = ID_ReadData2;
        imm_d       = ID_Imm;
        ctrl_d      = ID_Ctrl;
        aluop_d     = ID_ALUOp;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= 1'b0;
      reg_rs_q    <= '0;
      reg_rt_q    <= '0;
      write_reg_q <= '0;
      rd1_q       <= '0;
      rd2_q       <= '0;
      imm_q       <= '0;
      ctrl_q      <= '0;
      aluop_q     <= '0;
    end else begin
      valid_q     <= valid_d;
      reg_rs_q    <= reg_rs_d;
      reg_rt_q    <= reg_rt_d;
      write_reg_q <= write_reg_d;
      rd1_q       <= rd1_d;
      rd2_q       <= rd2_d;
      imm_q       <= imm_d;
      ctrl_q      <= ctrl_d;
      aluop_q     <= aluop_d;
    end
  end

  assign IDEX_Valid     = valid_q;
  assign IDEX_RegRs     = reg_rs_q;
  assign IDEX_RegRt     = reg_rt_q;
  assign IDEX_WriteReg  = write_reg_q;
  assign IDEX_ReadData1 = rd1_q;
  assign IDEX_ReadData2 = rd2_q;
  assign IDEX_Imm       = imm_q;
  assign IDEX_Ctrl      = ctrl_q;
  assign IDEX_ALUOp     = aluop_q;

`ifdef IDEX_STALL_COUNT_EN
  logic [31:0] stall_count_q, stall_count_d;

  // Counts only load-use bubbles that actually enter EX
  always_comb begin
    stall_count_d = stall_count_q;
    if (!ExHold && !Flush && load_use && (stall_count_q != 32'hFFFF_FFFF))
      stall_count_d = stall_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) stall_count_q <= '0;
    else       stall_count_q <= stall_count_d;
  end

  assign StallCount = stall_count_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage; build with IDEX_STALL_COUNT_EN
// defined to include the stall-counter checks.
module tb_id_ex_stage;

  localparam logic [5:0] CTRL_LW  = 6'b111010;
  localparam logic [5:0] CTRL_ADD = 6'b100001;
  localparam logic [5:0] CTRL_SW  = 6'b000110;

  logic        clk = 1'b0;
  logic        reset;
  logic        ID_Valid;
  logic [4:0]  ID_RegRs, ID_RegRt, ID_RegRd;
  logic        ID_UsesRs, ID_UsesRt;
  logic [31:0] ID_ReadData1, ID_ReadData2, ID_Imm;
  logic [5:0]  ID_Ctrl;
  logic [3:0]  ID_ALUOp;
  logic        Flush, ExHold;
  logic        PCWrite, IFID_Write, IDEX_Valid;
  logic [4:0]  IDEX_RegRs, IDEX_RegRt, IDEX_WriteReg;
  logic [31:0] IDEX_ReadData1, IDEX_ReadData2, IDEX_Imm;
  logic [5:0]  IDEX_Ctrl;
  logic [3:0]  IDEX_ALUOp;
`ifdef IDEX_STALL_COUNT_EN
  logic [31:0] StallCount;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk            (clk),
    .reset          (reset),
    .ID_Valid       (ID_Valid),
    .ID_RegRs       (ID_RegRs),
    .ID_RegRt       (ID_RegRt),
    .ID_RegRd       (ID_RegRd),
    .ID_UsesRs      (ID_UsesRs),
    .ID_UsesRt      (ID_UsesRt),
    .ID_ReadData1   (ID_ReadData1),
    .ID_ReadData2   (ID_ReadData2),
    .ID_Imm         (ID_Imm),
    .ID_Ctrl        (ID_Ctrl),
    .ID_ALUOp       (ID_ALUOp),
    .Flush          (Flush),
    .ExHold         (ExHold),
    .PCWrite        (PCWrite),
    .IFID_Write     (IFID_Write),
    .IDEX_Valid     (IDEX_Valid),
    .IDEX_RegRs     (IDEX_RegRs),
    .IDEX_RegRt     (IDEX_RegRt),
    .IDEX_WriteReg  (IDEX_WriteReg),
    .IDEX_ReadData1 (IDEX_ReadData1),
    .IDEX_ReadData2 (IDEX_ReadData2),
    .IDEX_Imm       (IDEX_Imm),
    .IDEX_Ctrl      (IDEX_Ctrl),
    .IDEX_ALUOp     (IDEX_ALUOp)
`ifdef IDEX_STALL_COUNT_EN
    ,
    .StallCount     (StallCount)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic urs, input logic urt,
                        input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] imm, input logic [5:0] ctrl,
                        input logic [3:0] aluop);
    ID_Valid = v; ID_RegRs = rs; ID_RegRt = rt; ID_RegRd = rd;
    ID_UsesRs = urs; ID_UsesRt = urt; ID_ReadData1 = d1; ID_ReadData2 = d2;
    ID_Imm = imm; ID_Ctrl = ctrl; ID_ALUOp = aluop;
    #1;
  endtask

  initial begin
    reset = 1'b1; Flush = 1'b0; ExHold = 1'b0;
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 6'd0, 4'd0);
    step();
    step();
    check("rst_valid", 32'(IDEX_Valid), 32'd0);
    check("rst_rt",    32'(IDEX_RegRt), 32'd0);
    check("rst_ctrl",  32'(IDEX_Ctrl),  32'd0);
    check("rst_rd1",   IDEX_ReadData1,  32'd0);
`ifdef IDEX_STALL_COUNT_EN
    check("rst_cnt",   StallCount,      32'd0);
`endif
    reset = 1'b0;

    // lw $8,0($4) then dependent add $9,$8,$3
    set_id(1'b1, 5'd4, 5'd8, 5'd0, 1'b1, 1'b0, 32'h40, 32'h0, 32'h0, CTRL_LW, 4'd2);
    step();
    check("lw_valid", 32'(IDEX_Valid),    32'd1);
    check("lw_wreg",  32'(IDEX_WriteReg), 32'd8);
    check("lw_ctrl",  32'(IDEX_Ctrl),     32'(CTRL_LW));
    set_id(1'b1, 5'd8, 5'd3, 5'd9, 1'b1, 1'b1, 32'h11, 32'h22, 32'h0, CTRL_ADD, 4'd2);
    check("lu_pcw",   32'(PCWrite),    32'd0);
    check("lu_ifid",  32'(IFID_Write), 32'd0);
    step();
    check("lu_bub_valid", 32'(IDEX_Valid), 32'd0);
    check("lu_bub_ctrl",  32'(IDEX_Ctrl),  32'd0);
    check("lu_bub_rs",    32'(IDEX_RegRs), 32'd0);
    check("lu_pcw_rel",   32'(PCWrite),    32'd1);
    step();
    check("add_valid", 32'(IDEX_Valid),    32'd1);
    check("add_rs",    32'(IDEX_RegRs),    32'd8);
    check("add_wreg",  32'(IDEX_WriteReg), 32'd9);
    check("add_rd1",   IDEX_ReadData1,     32'h11);
    check("add_rd2",   IDEX_ReadData2,     32'h22);
    check("add_aluop", 32'(IDEX_ALUOp),    32'd2);
`ifdef IDEX_STALL_COUNT_EN
    check("cnt_one", StallCount, 32'd1);
`endif

    // lw $8 then sw $8,4($5): store data is forwarded, no stall
    set_id(1'b1, 5'd4, 5'd8, 5'd0, 1'b1, 1'b0, 32'h40, 32'h0, 32'h0, CTRL_LW, 4'd2);
    step();
    set_id(1'b1, 5'd5, 5'd8, 5'd0, 1'b1, 1'b1, 32'h50, 32'h88, 32'h4, CTRL_SW, 4'd2);
    check("sw_pcw", 32'(PCWrite), 32'd1);
    step();
    check("sw_valid", 32'(IDEX_Valid), 32'd1);
    check("sw_rt",    32'(IDEX_RegRt), 32'd8);
    check("sw_imm",   IDEX_Imm,        32'h4);
    check("sw_ctrl",  32'(IDEX_Ctrl),  32'(CTRL_SW));

    // lw $0 then add $9,$0,$0: never stalls
    set_id(1'b1, 5'd4, 5'd0, 5'd0, 1'b1, 1'b0, 32'h40, 32'h0, 32'h0, CTRL_LW, 4'd2);
    step();
    set_id(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0, CTRL_ADD, 4'd2);
    check("z_pcw", 32'(PCWrite), 32'd1);
    step();
    check("z_valid", 32'(IDEX_Valid),    32'd1);
    check("z_wreg",  32'(IDEX_WriteReg), 32'd9);

    // Flush together with load-use: flush wins, PC keeps moving
    set_id(1'b1, 5'd4, 5'd8, 5'd0, 1'b1, 1'b0, 32'h40, 32'h0, 32'h0, CTRL_LW, 4'd2);
    step();
    set_id(1'b1, 5'd8, 5'd3, 5'd9, 1'b1, 1'b1, 32'h11, 32'h22, 32'h0, CTRL_ADD, 4'd2);
    Flush = 1'b1;
    #1;
    check("fl_pcw", 32'(PCWrite), 32'd1);
    step();
    Flush = 1'b0;
    check("fl_valid", 32'(IDEX_Valid), 32'd0);
    check("fl_ctrl",  32'(IDEX_Ctrl),  32'd0);
`ifdef IDEX_STALL_COUNT_EN
    check("fl_cnt", StallCount, 32'd1);
`endif

    // ExHold for 3 cycles with ID changing (and a Flush inside the hold)
    set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 32'hAAAA, 32'h5555, 32'h0, CTRL_ADD, 4'd5);
    step();
    check("h_pre_rd1", IDEX_ReadData1, 32'hAAAA);
    ExHold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, 5'(6 + i), 5'd7, 5'd10, 1'b1, 1'b1, 32'hBBB0 + 32'(i), 32'h0, 32'h0,
             CTRL_ADD, 4'd3);
      Flush = (i == 1);
      #1;
      check("h_pcw", 32'(PCWrite), 32'd0);
      step();
      check("h_rd1",   IDEX_ReadData1,     32'hAAAA);
      check("h_rs",    32'(IDEX_RegRs),    32'd1);
      check("h_valid", 32'(IDEX_Valid),    32'd1);
    end
    ExHold = 1'b0;
    Flush  = 1'b0;
    #1;
    check("h_rel_pcw", 32'(PCWrite), 32'd1);
    step();
    check("h_rel_rd1",   IDEX_ReadData1,     32'hBBB2);
    check("h_rel_rs",    32'(IDEX_RegRs),    32'd8);
    check("h_rel_wreg",  32'(IDEX_WriteReg), 32'd10);
    check("h_rel_aluop", 32'(IDEX_ALUOp),    32'd3);

    // Invalid ID becomes a bubble
    set_id(1'b0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 32'h1, 32'h2, 32'h3, CTRL_ADD, 4'd1);
    step();
    check("inv_valid", 32'(IDEX_Valid), 32'd0);
    check("inv_rs",    32'(IDEX_RegRs), 32'd0);
    check("inv_rd1",   IDEX_ReadData1,  32'd0);

    // Reset during a load-use cycle
    set_id(1'b1, 5'd4, 5'd8, 5'd0, 1'b1, 1'b0, 32'h40, 32'h0, 32'h0, CTRL_LW, 4'd2);
    step();
    set_id(1'b1, 5'd8, 5'd3, 5'd9, 1'b1, 1'b1, 32'h11, 32'h22, 32'h0, CTRL_ADD, 4'd2);
    reset = 1'b1;
    #1;
    check("rs_pcw", 32'(PCWrite), 32'd0);
    step();
    reset = 1'b0;
    #1;
    check("rs_valid", 32'(IDEX_Valid), 32'd0);
    check("rs_rt",    32'(IDEX_RegRt), 32'd0);
    check("rs_ctrl",  32'(IDEX_Ctrl),  32'd0);
    check("rs_pcw_after", 32'(PCWrite), 32'd1);
`ifdef IDEX_STALL_COUNT_EN
    check("rs_cnt", StallCount, 32'd0);

    // Saturation at all-ones
    set_id(1'b1, 5'd4, 5'd8, 5'd0, 1'b1, 1'b0, 32'h40, 32'h0, 32'h0, CTRL_LW, 4'd2);
    step();
    set_id(1'b1, 5'd8, 5'd3, 5'd9, 1'b1, 1'b1, 32'h11, 32'h22, 32'h0, CTRL_ADD, 4'd2);
    force dut.stall_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_count_q;
    step();
    check("sat_valid", 32'(IDEX_Valid), 32'd0);
    check("sat_cnt",   StallCount,      32'hFFFF_FFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
